// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock first-in/first-out buffer with registered read data,
// occupancy flags, programmable almost-full / almost-empty thresholds
// and an occupancy count.
//
// Parameters
//   DATA_W  : data width in bits (1..64)
//   DEPTH   : number of entries, power of two, >= 2
//   AF_LVL  : almost_full asserts when count >= AF_LVL
//   AE_LVL  : almost_empty asserts when count <= AE_LVL
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   wr_en        in   write request
//   data_in      in   write data            [DATA_W-1:0]
//   rd_en        in   read request
//   data_out     out  registered read data  [DATA_W-1:0]
//   full         out  all DEPTH entries occupied
//   empty        out  no entries occupied
//   almost_full  out  count >= AF_LVL
//   almost_empty out  count <= AE_LVL
//   count        out  occupancy 0..DEPTH    [log2(DEPTH):0]
//
// Optional feature, macro FIFO_ERR_EN:
//   err_clr      in   clears the sticky error flags
//   overflow     out  sticky: a write was refused because the FIFO was full
//   underflow    out  sticky: a read was refused because the FIFO was empty
// With FIFO_ERR_EN undefined these three ports and their logic are absent.
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
`ifdef FIFO_ERR_EN
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    err_clr,
  output logic                    overflow,
  output logic                    underflow
`else
  output logic [$clog2(DEPTH):0]  count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] AF_THR = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LVL);

  // Storage is deliberately left without reset; only the pointers define
  // which entries are meaningful.
  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits coincide.
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     count_q;
  logic [DATA_W-1:0] data_out_q;

  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              full_c;
  logic              empty_c;
  logic              wr_accept;
  logic              rd_accept;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Occupancy flags come straight from registered pointers, so they are
  // valid in the same cycle as count.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);

  // A read is only possible when something is stored. A write into a full
  // FIFO is allowed when a read frees a slot in the same cycle. When empty,
  // a simultaneous read is refused: there is no write-to-read bypass.
  assign rd_accept = rd_en && !empty_c;
  assign wr_accept = wr_en && (!full_c || rd_accept);

  // Storage write port. When full with both requests accepted, the write
  // address equals the read address; the read below samples the old value
  // because both are non-blocking updates on the same edge.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Pointer, count and read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr     <= rd_ptr + PW'(1);
        data_out_q <= mem[rd_addr];
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = (count_q >= AF_THR);
  assign almost_empty = (count_q <= AE_THR);

`ifdef FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;
  logic overflow_evt;
  logic underflow_evt;

  // A refused request is an error event.
  assign overflow_evt  = wr_en && !wr_accept;
  assign underflow_evt = rd_en && !rd_accept;

  // Sticky error flags. A clear loses to a new event in the same cycle so
  // that no error can slip through unseen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  && !err_clr) || overflow_evt;
      underflow_q <= (underflow_q && !err_clr) || underflow_evt;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=8). A queue
// based reference model predicts every output after each clock; directed
// sequences cover fill/drain, wrap-around, simultaneous requests, async
// reset, then a randomized phase exercises arbitrary traffic.
// Build with FIFO_ERR_EN defined to also check the error flags.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = DEPTH - 1;
  localparam int AE_LVL = 1;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [3:0]        count;
  logic              err_clr;
`ifdef FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  int cmp_count  = 0;
  int fail_count = 0;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_dout;
  logic              model_ovf;
  logic              model_unf;

  sync_fifo_param #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AF_LVL(AF_LVL),
    .AE_LVL(AE_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`ifdef FIFO_ERR_EN
    .count       (count),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
`else
    .count       (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    cmp_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Compare every visible output with the model's prediction.
  task automatic checkAll(input string ctx);
    int n;
    n = model_q.size();
    checkOutput({ctx, ".count"},        64'(count),        64'(n));
    checkOutput({ctx, ".empty"},        64'(empty),        64'(n == 0));
    checkOutput({ctx, ".full"},         64'(full),         64'(n == DEPTH));
    checkOutput({ctx, ".almost_full"},  64'(almost_full),  64'(n >= AF_LVL));
    checkOutput({ctx, ".almost_empty"}, 64'(almost_empty), 64'(n <= AE_LVL));
    checkOutput({ctx, ".data_out"},     64'(data_out),     64'(model_dout));
`ifdef FIFO_ERR_EN
    checkOutput({ctx, ".overflow"},     64'(overflow),     64'(model_ovf));
    checkOutput({ctx, ".underflow"},    64'(underflow),    64'(model_unf));
`endif
  endtask

  // Drive one cycle of requests, advance the model by the FIFO rules,
  // then check all outputs shortly after the edge.
  task automatic applyStimulus(input logic wr, input logic [DATA_W-1:0] din,
                               input logic rd, input logic clr, input string ctx);
    logic rd_ok;
    logic wr_ok;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    err_clr = clr;
    @(posedge clk);
    #1;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) model_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(din);
    model_ovf = (model_ovf && !clr) || (wr && !wr_ok);
    model_unf = (model_unf && !clr) || (rd && !rd_ok);
    checkAll(ctx);
  endtask

  task automatic modelReset();
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
  endtask

  initial begin
    logic rw;
    logic ww;
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    err_clr = 1'b0;
    modelReset();

    // Reset state, checked while reset is held
    #2;
    checkAll("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAll("reset_release");

    // Fill with 0..7
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, "fill");
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_count", 64'(count), 64'd8);

    // Drain: data_out 0..7
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain");
      checkOutput("drain_order", 64'(data_out), 64'(i));
    end
    checkOutput("drain_empty", 64'(empty), 64'd1);

    // Wrap-around: write 8, read 4, write 8..11, read 8
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, "wrap_w1");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "wrap_r1");
    for (int i = 8; i < 12; i++)
      applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, "wrap_w2");
    for (int i = 4; i < 12; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "wrap_r2");
      checkOutput("wrap_order", 64'(data_out), 64'(i));
    end

    // Full with simultaneous read and write of 0xAA
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0, "sim_fill");
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, "sim_full");
    checkOutput("sim_full_count", 64'(count), 64'd8);
    checkOutput("sim_full_oldest", 64'(data_out), 64'h10);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "sim_drain");
    checkOutput("sim_last_aa", 64'(data_out), 64'hAA);

    // Empty with simultaneous read and write of 0x55: write only
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, "sim_empty");
    checkOutput("sim_empty_count", 64'(count), 64'd1);
    checkOutput("sim_empty_dout", 64'(data_out), 64'hAA);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, "sim_empty_rd");
    checkOutput("sim_empty_55", 64'(data_out), 64'h55);

    // Overflow: fill, a 9th write is refused, flag sticky until err_clr
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b0, "ovf_fill");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, "ovf_9th");
    checkOutput("ovf_count", 64'(count), 64'd8);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "ovf_hold");
`ifdef FIFO_ERR_EN
    checkOutput("ovf_sticky", 64'(overflow), 64'd1);
`endif
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
`ifdef FIFO_ERR_EN
    checkOutput("ovf_cleared", 64'(overflow), 64'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
      checkOutput("ovf_order", 64'(data_out), 64'(8'h30 + i));
    end

    // Async reset mid-burst at count 5
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, DATA_W'(8'h60 + i), 1'b0, 1'b0, "rst_fill");
    checkOutput("rst_pre_count", 64'(count), 64'd5);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_count", 64'(count), 64'd0);
    checkOutput("async_empty", 64'(empty), 64'd1);
    checkOutput("async_dout", 64'(data_out), 64'd0);
    checkAll("async_rst");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_w");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "post_rst_r");
    checkOutput("post_rst_first", 64'(data_out), 64'h77);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      ww = ($urandom_range(0, 99) < 55);
      rw = ($urandom_range(0, 99) < 50);
      applyStimulus(ww, DATA_W'($urandom), rw,
                    ($urandom_range(0, 9) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             cmp_count, fail_count);
    $finish;
  end

endmodule
